gestor_solicitudes: RTL and testbench
=====================================

// Module: gestor_solicitudes
// PURPOSE
//  Request store and dispatcher feeding the elevator state machine. Latches hall/cab
//  button codes, clears them when the car serves a floor, and presents one 4-bit
//  request code on `memoria` using collective (SCAN) ordering. Its inputs are the
//  elevator's piso/accion/puertas outputs; its `memoria` output drives the elevator.
// PARAMETERS
//  PRIORIDAD_SUBIR  1  tie-break when idle and equidistant: 1 = serve upper floor, 0 = lower
// PORTS
//  clk             in   1   clock; all state changes on posedge
//  rst             in   1   asynchronous, active-high reset
//  boton_valido    in   1   1-cycle strobe: boton_pres is valid this cycle
//  boton_pres      in   4   button code 1..10 (1-4 cab floor 1-4; 5 F1 up; 6/7 F2 down/up;
//                           8/9 F3 down/up; 10 F4 down)
//  piso            in   2   current floor 0..3, from the elevator
//  accion          in   2   0 stopped, 1 up, 2 down, from the elevator
//  puertas         in   1   1 = doors open, from the elevator
//  memoria         out  4   request code presented to the elevator, 0 = none
//  direccion       out  2   internal sweep direction: 0 idle, 1 up, 2 down
//  pendientes      out  10  pending bitmap; bit i-1 = code i
//  hay_pendientes  out  1   |pendientes
// BEHAVIOUR
//  Reset (async, immediate): memoria=0, direccion=0, pendientes=0, hay_pendientes=0.
//   Reset asserted mid-operation discards all pending requests.
//  Floor map: F0 = {1,5}, F1 = {2,6,7}, F2 = {3,8,9}, F3 = {4,10}.
//  Capture: on an edge with boton_valido=1 and boton_pres in 1..10, set that bit.
//   Codes 0 and 11..15 are ignored.
//  Service clear: on an edge with puertas=1 and accion=0, clear every bit of floor piso.
//   Set and clear on the same bit in the same edge: clear wins (already served).
//   Re-pressing an already-pending code has no effect.
//  Dispatch is registered. memoria and direccion update every edge from the pending
//   bitmap as it was before that edge. Latency press -> memoria is 2 edges.
//   Target floor T, in priority order:
//   a) no bits pending: memoria=0, direccion=0.
//   b) a bit pending at floor piso: T=piso; direccion unchanged.
//   c) direccion=1 and any floor above piso pending: T = nearest pending floor above.
//      Otherwise, if any floor below is pending: direccion <= 2, T = nearest below.
//   d) direccion=2: mirror image of c).
//   e) direccion=0: T = nearest pending floor. Equidistant floors are broken by
//      PRIORIDAD_SUBIR. direccion <= 1 if T>piso, 2 if T<piso.
//   memoria = lowest-numbered pending code in floor T's set.
//  memoria therefore stays stable while the car travels toward T, unless a nearer floor
//   in the current sweep direction is requested first.
//  hay_pendientes is combinational from pendientes.
//  All arithmetic is on 2-bit floor indices 0..3; no wrap-around.
//  direccion=3 is never produced. If it is reached, it is treated as 0.
// TESTING
//  1 Pulse rst mid-sequence with 3 bits pending -> memoria=0, pendientes=0 immediately,
//    before the next clk edge.
//  2 piso=0, idle; press code 3 -> pendientes=10'h004 after edge 1; memoria=3,
//    direccion=1 after edge 2.
//  3 piso=2, direccion=1, pending {1,4} -> memoria=4. Drive piso=3, puertas=1, accion=0
//    -> code 4 cleared; memoria=1, direccion=2.
//  4 piso=1, idle, pending {1,3}: PRIORIDAD_SUBIR=1 -> memoria=3, direccion=1;
//    PRIORIDAD_SUBIR=0 -> memoria=1, direccion=2.
//  5 piso=1, puertas=1, accion=0; press code 6 -> bit 5 stays 0. Press code 9 in the
//    same setup -> bit 8 set; memoria=9 once puertas=0.
//  6 Press codes 0, 11, 15 -> pendientes unchanged, memoria=0. Press code 7 twice while
//    pending -> single bit, cleared once.

Source files
------------

// File: rtl/gestor_solicitudes.sv
`default_nettype none
// ============================================================================
// Module      : gestor_solicitudes
// Description : Request store and dispatcher for the elevator controller.
//               Latches hall/cab button codes into a pending bitmap, clears a
//               floor's codes when the car stands there with doors open, and
//               presents one request code on `memoria` using collective (SCAN)
//               ordering with a registered sweep direction.
// Ports       : clk            - clock, all state changes on posedge
//               rst            - asynchronous active-high reset
//               boton_valido   - 1-cycle strobe qualifying boton_pres
//               boton_pres[3:0]- button code 1..10 (others ignored)
//               piso[1:0]      - current floor 0..3 from the elevator
//               accion[1:0]    - 0 stopped, 1 up, 2 down
//               puertas        - 1 = doors open
//               memoria[3:0]   - request code to the elevator, 0 = none
//               direccion[1:0] - sweep direction: 0 idle, 1 up, 2 down
//               pendientes[9:0]- pending bitmap, bit i-1 = code i
//               hay_pendientes - |pendientes
// Revision    : 1.0 - initial release
// ============================================================================
module gestor_solicitudes #(
  parameter bit PRIORIDAD_SUBIR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       boton_valido,
  input  logic [3:0] boton_pres,
  input  logic [1:0] piso,
  input  logic [1:0] accion,
  input  logic       puertas,
  output logic [3:0] memoria,
  output logic [1:0] direccion,
  output logic [9:0] pendientes,
  output logic       hay_pendientes
);

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  localparam logic [1:0] c_ACC_STOP = 2'd0;

  dir_t       r_dir;
  logic [9:0] r_pend;

  logic [9:0] w_set;
  logic [9:0] w_clr;
  logic [3:0] w_floor_pend;
  logic       w_has_up;
  logic       w_has_dn;
  logic [1:0] w_up;
  logic [1:0] w_dn;
  logic [1:0] w_dist_up;
  logic [1:0] w_dist_dn;
  logic [1:0] w_tgt;
  dir_t       w_dir_next;
  dir_t       w_dir_cur;

  // Codes belonging to each floor: F0 {1,5}, F1 {2,6,7}, F2 {3,8,9}, F3 {4,10}
  function automatic logic [9:0] floor_mask(input logic [1:0] f);
    case (f)
      2'd0:    floor_mask = 10'b00_0001_0001;
      2'd1:    floor_mask = 10'b00_0110_0010;
      2'd2:    floor_mask = 10'b01_1000_0100;
      default: floor_mask = 10'b10_0000_1000;
    endcase
  endfunction

  // Lowest-numbered pending code on floor f (caller guarantees one is pending)
  function automatic logic [3:0] lowest_code(input logic [9:0] p, input logic [1:0] f);
    case (f)
      2'd0:    lowest_code = p[0] ? 4'd1 : 4'd5;
      2'd1:    lowest_code = p[1] ? 4'd2 : (p[5] ? 4'd6 : 4'd7);
      2'd2:    lowest_code = p[2] ? 4'd3 : (p[7] ? 4'd8 : 4'd9);
      default: lowest_code = p[3] ? 4'd4 : 4'd10;
    endcase
  endfunction

  // Capture and service-clear masks for this edge
  always_comb begin
    w_set = '0;
    if (boton_valido && (boton_pres >= 4'd1) && (boton_pres <= 4'd10)) begin
      w_set = 10'd1 << (boton_pres - 4'd1);
    end
    w_clr = '0;
    if (puertas && (accion == c_ACC_STOP)) begin
      w_clr = floor_mask(piso);
    end
  end

  // Per-floor pending flags and nearest pending floors above/below the car
  always_comb begin
    w_floor_pend = '0;
    w_has_up     = 1'b0;
    w_has_dn     = 1'b0;
    w_up         = '0;
    w_dn         = '0;
    for (int f = 0; f < 4; f++) begin
      w_floor_pend[f] = |(r_pend & floor_mask(2'(f)));
    end
    // Descending scan: the last hit is the closest floor above
    for (int f = 3; f >= 0; f--) begin
      if ((f > int'(piso)) && w_floor_pend[f]) begin
        w_has_up = 1'b1;
        w_up     = 2'(f);
      end
    end
    // Ascending scan: the last hit is the closest floor below
    for (int f = 0; f < 4; f++) begin
      if ((f < int'(piso)) && w_floor_pend[f]) begin
        w_has_dn = 1'b1;
        w_dn     = 2'(f);
      end
    end
    w_dist_up = w_up - piso;
    w_dist_dn = piso - w_dn;
  end

  // Target floor and next sweep direction
  always_comb begin
    // An out-of-range direction behaves as idle
    case (r_dir)
      DIR_UP:   w_dir_cur = DIR_UP;
      DIR_DOWN: w_dir_cur = DIR_DOWN;
      default:  w_dir_cur = DIR_IDLE;
    endcase
    w_tgt      = piso;
    w_dir_next = w_dir_cur;
    if (r_pend == '0) begin
      w_dir_next = DIR_IDLE;
    end else if (w_floor_pend[piso]) begin
      w_tgt = piso;
    end else begin
      case (w_dir_cur)
        DIR_UP: begin
          if (w_has_up) begin
            w_tgt = w_up;
          end else begin
            w_tgt      = w_dn;
            w_dir_next = DIR_DOWN;
          end
        end
        DIR_DOWN: begin
          if (w_has_dn) begin
            w_tgt = w_dn;
          end else begin
            w_tgt      = w_up;
            w_dir_next = DIR_UP;
          end
        end
        default: begin
          // Choose upward when only up exists, when up is strictly closer,
          // or on a tie when upward priority is configured
          if (w_has_up && (!w_has_dn || (w_dist_up < w_dist_dn) ||
                           ((w_dist_up == w_dist_dn) && PRIORIDAD_SUBIR))) begin
            w_tgt      = w_up;
            w_dir_next = DIR_UP;
          end else begin
            w_tgt      = w_dn;
            w_dir_next = DIR_DOWN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend  <= '0;
      r_dir   <= DIR_IDLE;
      memoria <= '0;
    end else begin
      // Clear applied after set: a code pressed at the floor being served is dropped
      r_pend  <= (r_pend | w_set) & ~w_clr;
      r_dir   <= w_dir_next;
      memoria <= (r_pend == '0) ? 4'd0 : lowest_code(r_pend, w_tgt);
    end
  end

  assign direccion      = r_dir;
  assign pendientes     = r_pend;
  assign hay_pendientes = |r_pend;

endmodule
`default_nettype wire

// File: tb/tb_gestor_solicitudes.sv
`default_nettype none
// ============================================================================
// Module      : tb_gestor_solicitudes
// Description : Scoreboard bench for gestor_solicitudes. Two instances share
//               the inputs, one per tie-break priority. A behavioural model
//               pushes expected outputs per edge; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gestor_solicitudes;

  logic       clk = 1'b0;
  logic       rst;
  logic       boton_valido;
  logic [3:0] boton_pres;
  logic [1:0] piso;
  logic [1:0] accion;
  logic       puertas;

  logic [3:0] mem_a, mem_b;
  logic [1:0] dir_a, dir_b;
  logic [9:0] pend_a, pend_b;
  logic       hay_a, hay_b;

  always #5 clk = ~clk;

  gestor_solicitudes #(.PRIORIDAD_SUBIR(1'b1)) dut_up (
    .clk(clk), .rst(rst), .boton_valido(boton_valido), .boton_pres(boton_pres),
    .piso(piso), .accion(accion), .puertas(puertas),
    .memoria(mem_a), .direccion(dir_a), .pendientes(pend_a), .hay_pendientes(hay_a)
  );

  gestor_solicitudes #(.PRIORIDAD_SUBIR(1'b0)) dut_dn (
    .clk(clk), .rst(rst), .boton_valido(boton_valido), .boton_pres(boton_pres),
    .piso(piso), .accion(accion), .puertas(puertas),
    .memoria(mem_b), .direccion(dir_b), .pendientes(pend_b), .hay_pendientes(hay_b)
  );

  typedef struct packed {
    logic [9:0] pend;
    logic [3:0] mem_a;
    logic [1:0] dir_a;
    logic [3:0] mem_b;
    logic [1:0] dir_b;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state: pending set of codes and each instance's sweep direction
  bit m_pend[1:10];
  int m_dir[2];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int floor_of(input int c);
    if (c <= 4) return c - 1;
    if (c == 5) return 0;
    if (c <= 7) return 1;
    if (c <= 9) return 2;
    return 3;
  endfunction

  // Dispatch decision from the pending set before the edge
  function automatic void dispatch(input int p, input int dir_in, input bit pri,
                                   output int mem, output int ndir);
    bit fp[4];
    bit any;
    int dir, t, up, dn, bd, d;
    any = 0;
    for (int f = 0; f < 4; f++) fp[f] = 0;
    for (int c = 1; c <= 10; c++) if (m_pend[c]) begin any = 1; fp[floor_of(c)] = 1; end
    dir = (dir_in == 1 || dir_in == 2) ? dir_in : 0;
    if (!any) begin mem = 0; ndir = 0; return; end
    t = p; ndir = dir;
    if (!fp[p]) begin
      up = -1; dn = -1;
      for (int f = 3; f > p; f--) if (fp[f]) up = f;
      for (int f = 0; f < p; f++) if (fp[f]) dn = f;
      if (dir == 1) begin
        if (up >= 0) t = up; else begin t = dn; ndir = 2; end
      end else if (dir == 2) begin
        if (dn >= 0) t = dn; else begin t = up; ndir = 1; end
      end else begin
        t = -1; bd = 99;
        for (int f = 0; f < 4; f++) begin
          if (fp[f] && f != p) begin
            d = (f > p) ? f - p : p - f;
            if (d < bd || (d == bd && (pri ? (f > p) : (f < p)))) begin
              t = f; bd = d;
            end
          end
        end
        ndir = (t > p) ? 1 : 2;
      end
    end
    mem = 0;
    for (int c = 10; c >= 1; c--) if (m_pend[c] && floor_of(c) == t) mem = c;
  endfunction

  function automatic logic [9:0] model_bitmap();
    logic [9:0] b;
    b = '0;
    for (int c = 1; c <= 10; c++) b[c-1] = m_pend[c];
    return b;
  endfunction

  task automatic model_reset();
    for (int c = 1; c <= 10; c++) m_pend[c] = 0;
    m_dir[0] = 0;
    m_dir[1] = 0;
  endtask

  // Apply one edge's inputs and queue the outputs expected after that edge
  task automatic drive(input bit v, input int code, input int p, input int a, input bit pu);
    exp_t e;
    int   ma, da, mb, db;
    @(negedge clk);
    boton_valido = v;
    boton_pres   = 4'(code);
    piso         = 2'(p);
    accion       = 2'(a);
    puertas      = pu;
    dispatch(p, m_dir[1], 1'b1, ma, da);
    dispatch(p, m_dir[0], 1'b0, mb, db);
    if (v && code >= 1 && code <= 10) m_pend[code] = 1;
    if (pu && a == 0) for (int c = 1; c <= 10; c++) if (floor_of(c) == p) m_pend[c] = 0;
    m_dir[1] = da;
    m_dir[0] = db;
    e.pend  = model_bitmap();
    e.mem_a = 4'(ma);
    e.dir_a = 2'(da);
    e.mem_b = 4'(mb);
    e.dir_b = 2'(db);
    q.push_back(e);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_pend_a"}, int'(pend_a), 0);
    chk({tag, "_pend_b"}, int'(pend_b), 0);
    chk({tag, "_mem_a"},  int'(mem_a), 0);
    chk({tag, "_mem_b"},  int'(mem_b), 0);
    chk({tag, "_dir_a"},  int'(dir_a), 0);
    chk({tag, "_hay_a"},  int'(hay_a), 0);
  endtask

  // Reset asserted between edges must clear outputs before the next edge
  task automatic async_reset();
    @(negedge clk);
    boton_valido = 0;
    puertas      = 0;
    accion       = 0;
    #2 rst = 1;
    #1 check_cleared("async_rst");
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  // Monitor: compare every edge for which an expectation was queued
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pend_a", int'(pend_a), int'(e.pend));
        chk("pend_b", int'(pend_b), int'(e.pend));
        chk("hay_a",  int'(hay_a),  int'(e.pend != 0));
        chk("mem_a",  int'(mem_a),  int'(e.mem_a));
        chk("dir_a",  int'(dir_a),  int'(e.dir_a));
        chk("mem_b",  int'(mem_b),  int'(e.mem_b));
        chk("dir_b",  int'(dir_b),  int'(e.dir_b));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    rst = 1;
    boton_valido = 0; boton_pres = 0; piso = 0; accion = 0; puertas = 0;
    model_reset();
    #3 check_cleared("reset");
    @(negedge clk);
    rst = 0;

    // Press code 3 from floor 0 while idle
    drive(1, 3, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    // Three codes pending, then reset between edges
    drive(1, 5, 0, 1, 0);
    drive(1, 8, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    async_reset();

    // Up sweep at floor 2 with {1,4}; serve floor 3 then reverse
    drive(1, 4, 2, 0, 0);
    drive(1, 1, 2, 0, 0);
    drive(0, 0, 2, 1, 0);
    drive(0, 0, 2, 1, 0);
    drive(0, 0, 3, 0, 1);
    drive(0, 0, 3, 0, 0);
    drive(0, 0, 3, 0, 0);
    async_reset();

    // Idle at floor 1 with {1,3}: tie broken by priority
    drive(1, 1, 0, 0, 0);
    drive(1, 3, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    async_reset();

    // Press at the served floor is dropped; other floors latch
    drive(1, 6, 1, 0, 1);
    drive(1, 9, 1, 0, 1);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    async_reset();

    // Invalid codes, duplicate press, single clear
    drive(1, 0, 0, 0, 0);
    drive(1, 11, 0, 0, 0);
    drive(1, 15, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 7, 0, 1, 0);
    drive(1, 7, 0, 1, 0);
    drive(0, 0, 1, 0, 1);
    drive(0, 0, 1, 0, 0);

    // Random traffic with a wandering car
    p = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1 && p < 3) p++;
        else if (p > 0) p--;
      end
      drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)), p,
            int'($urandom_range(0, 2)), $urandom_range(0, 3) == 0);
      if (i == 750) async_reset();
    end
    drive(0, 0, p, 1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
